// File: rtl/led_flash_engine.sv
// Multi-LED flash sequencer: flashes a latched LED group N times with a run-time half-period.
// Optional macro LED_FLASH_ALT_EN adds an 'alt' input for alternating even/odd LED flashing.
module led_flash_engine #(
  parameter int NUM_LEDS = 8,
  parameter int CNT_W    = 8,
  parameter int DIV_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    flash_num,
  input  logic [DIV_W-1:0]    half_period,
  input  logic [NUM_LEDS-1:0] led_mask,
`ifdef LED_FLASH_ALT_EN
  input  logic                alt,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    timer_q, timer_d;
  logic [DIV_W-1:0]    h_m1_q, h_m1_d;
  logic [CNT_W-1:0]    flash_cnt_q, flash_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timer_done;

`ifdef LED_FLASH_ALT_EN
  logic alt_q, alt_d;

  function automatic logic [NUM_LEDS-1:0] even_bits();
    logic [NUM_LEDS-1:0] r;
    for (int i = 0; i < NUM_LEDS; i++) r[i] = ((i % 2) == 0);
    return r;
  endfunction

  localparam logic [NUM_LEDS-1:0] EVEN = even_bits();
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      h_m1_q      <= '0;
      flash_cnt_q <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LED_FLASH_ALT_EN
      alt_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      h_m1_q      <= h_m1_d;
      flash_cnt_q <= flash_cnt_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LED_FLASH_ALT_EN
      alt_q       <= alt_d;
`endif
    end
  end

  // Phase timer counts 0..H-1; H-1 is stored so a zero half-period behaves as one cycle.
  assign timer_done = (timer_q == h_m1_q);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    h_m1_d      = h_m1_q;
    flash_cnt_d = flash_cnt_q;
    count_d     = count_q;
    mask_d      = mask_q;
`ifdef LED_FLASH_ALT_EN
    alt_d       = alt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          count_d     = flash_num;
          h_m1_d      = (half_period == '0) ? '0 : half_period - DIV_W'(1);
          mask_d      = led_mask;
`ifdef LED_FLASH_ALT_EN
          alt_d       = alt;
`endif
          timer_d     = '0;
          flash_cnt_d = '0;
          state_d     = (flash_num == '0) ? DONE : ON;
        end
      end
      ON: begin
        if (stop) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_done) begin
          timer_d = '0;
          state_d = OFF;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      OFF: begin
        if (stop) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_done) begin
          timer_d     = '0;
          flash_cnt_d = flash_cnt_q + CNT_W'(1);
          state_d     = (flash_cnt_d == count_q) ? DONE : ON;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      DONE: begin
        flash_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the transition.
  always_comb begin
    led_d  = '0;
    busy_d = 1'b0;
    done_d = (state_d == DONE);
    case (state_d)
      ON: begin
        busy_d = 1'b1;
`ifdef LED_FLASH_ALT_EN
        led_d  = alt_d ? (mask_d & EVEN) : mask_d;
`else
        led_d  = mask_d;
`endif
      end
      OFF: begin
        busy_d = 1'b1;
`ifdef LED_FLASH_ALT_EN
        led_d  = alt_d ? (mask_d & ~EVEN) : '0;
`else
        led_d  = '0;
`endif
      end
      default: ;
    endcase
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
